// File: rtl/freq_meter_core.sv
// Reciprocal frequency meter: counts whole sig_in periods and sys_clk cycles over a
// gate opened/closed on sig_in rising edges; results are published only while nCS is high.
module freq_meter_core #(
  parameter int unsigned GATE_CYCLES    = 50_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
  parameter int unsigned CNT_W          = 48
) (
  input  logic               sys_clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               sig_in,
  input  logic               nCS,
  output logic [2*CNT_W-1:0] send_data,
  output logic               result_valid,
  output logic               no_signal,
  output logic               overflow
);

  // Gate and timeout timers are independent of the result counters, so a
  // saturated std_cnt never stalls gate closure.
  localparam int unsigned TMR_W = 32;
  localparam logic [TMR_W-1:0] GATE_LIM = TMR_W'(GATE_CYCLES);
  localparam logic [TMR_W-1:0] TO_LIM   = TMR_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;

  typedef struct packed {
    logic [CNT_W-1:0] sig_c;
    logic [CNT_W-1:0] std_c;
    logic             nos;
    logic             ovf;
  } res_t;

  logic [2:0]       sig_sync;
  logic [1:0]       ncs_sync;
  logic             sig_rise;
  logic             ncs_s;

  state_t           state;
  logic [CNT_W-1:0] sig_cnt;
  logic [CNT_W-1:0] std_cnt;
  logic [TMR_W-1:0] gate_cnt;
  logic [TMR_W-1:0] to_cnt;
  logic             nos_r;
  logic             ovf_r;
  res_t             res_buf;
  logic             pending;

  logic             sig_sat;
  logic             std_sat;
  logic [CNT_W-1:0] sig_inc;
  logic [CNT_W-1:0] std_inc;
  logic [TMR_W-1:0] gate_nxt;
  logic [TMR_W-1:0] to_nxt;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_sync <= '0;
      ncs_sync <= '0;
    end else begin
      sig_sync <= {sig_sync[1:0], sig_in};
      ncs_sync <= {ncs_sync[0], nCS};
    end
  end

  assign sig_rise = sig_sync[1] & ~sig_sync[2];
  assign ncs_s    = ncs_sync[1];

  // Counters stick at all-ones rather than wrapping.
  assign sig_sat  = &sig_cnt;
  assign std_sat  = &std_cnt;
  assign sig_inc  = sig_sat ? sig_cnt : sig_cnt + CNT_W'(1);
  assign std_inc  = std_sat ? std_cnt : std_cnt + CNT_W'(1);
  assign gate_nxt = gate_cnt + TMR_W'(1);
  assign to_nxt   = to_cnt + TMR_W'(1);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      sig_cnt      <= '0;
      std_cnt      <= '0;
      gate_cnt     <= '0;
      to_cnt       <= '0;
      nos_r        <= 1'b0;
      ovf_r        <= 1'b0;
      res_buf      <= '0;
      pending      <= 1'b0;
      send_data    <= '0;
      result_valid <= 1'b0;
      no_signal    <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      result_valid <= 1'b0;

      // Publish first; a same-cycle DONE capture below overrides pending.
      if (pending && ncs_s) begin
        send_data    <= {res_buf.sig_c, res_buf.std_c};
        no_signal    <= res_buf.nos;
        overflow     <= res_buf.ovf;
        result_valid <= 1'b1;
        pending      <= 1'b0;
      end

      if (!enable) begin
        state    <= IDLE;
        sig_cnt  <= '0;
        std_cnt  <= '0;
        gate_cnt <= '0;
        to_cnt   <= '0;
        nos_r    <= 1'b0;
        ovf_r    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state    <= ARM;
            sig_cnt  <= '0;
            std_cnt  <= '0;
            gate_cnt <= '0;
            to_cnt   <= '0;
            nos_r    <= 1'b0;
            ovf_r    <= 1'b0;
          end

          ARM: begin
            if (sig_rise) begin
              state    <= MEASURE;
              sig_cnt  <= '0;
              std_cnt  <= '0;
              gate_cnt <= '0;
              to_cnt   <= '0;
              nos_r    <= 1'b0;
              ovf_r    <= 1'b0;
            end else if (to_nxt >= TO_LIM) begin
              state   <= DONE;
              sig_cnt <= '0;
              std_cnt <= '0;
              nos_r   <= 1'b1;
              ovf_r   <= 1'b0;
            end else begin
              to_cnt <= to_nxt;
            end
          end

          MEASURE: begin
            std_cnt  <= std_inc;
            gate_cnt <= gate_nxt;
            if (std_sat) ovf_r <= 1'b1;
            if (sig_rise) begin
              // The closing edge is itself counted.
              sig_cnt <= sig_inc;
              to_cnt  <= '0;
              if (sig_sat) ovf_r <= 1'b1;
              if (gate_nxt >= GATE_LIM) state <= DONE;
            end else if (to_nxt >= TO_LIM) begin
              state   <= DONE;
              sig_cnt <= '0;
              std_cnt <= '0;
              nos_r   <= 1'b1;
              ovf_r   <= 1'b0;
            end else begin
              to_cnt <= to_nxt;
            end
          end

          DONE: begin
            res_buf  <= '{sig_c: sig_cnt, std_c: std_cnt, nos: nos_r, ovf: ovf_r};
            pending  <= 1'b1;
            state    <= ARM;
            sig_cnt  <= '0;
            std_cnt  <= '0;
            gate_cnt <= '0;
            to_cnt   <= '0;
            nos_r    <= 1'b0;
            ovf_r    <= 1'b0;
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
